// File: rtl/axis_pattern_checker.sv
// Passive AXI4-Stream tap: matches first beat of each packet against
// masked pattern slots and reports hits, done, timeout and packet count.
module axis_pattern_checker #(
  parameter  int DATA_W  = 512,
  parameter  int NUM_PAT = 4,
  parameter  int TIMER_W = 16,
  parameter  int CNT_W   = 16,
  localparam int IDX_W   = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  s_axis_tdata,
  input  logic               s_axis_tvalid,
  input  logic               s_axis_tready,
  input  logic               s_axis_tlast,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [DATA_W-1:0]  cfg_pattern,
  input  logic [DATA_W-1:0]  cfg_mask,
  input  logic [NUM_PAT-1:0] cfg_en,
  input  logic               arm,
  input  logic [TIMER_W-1:0] timeout_cycles,
  output logic               busy,
  output logic               done,
  output logic               timed_out,
  output logic [NUM_PAT-1:0] hit,
  output logic [CNT_W-1:0]   pkt_cnt,
  output logic               cfg_err
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    DONE,
    TMO
  } state_t;

  state_t               r_state;
  logic [DATA_W-1:0]    r_pat  [NUM_PAT];
  logic [DATA_W-1:0]    r_mask [NUM_PAT];
  logic [NUM_PAT-1:0]   r_en_q;
  logic [NUM_PAT-1:0]   r_hit;
  logic [TIMER_W-1:0]   r_timer;
  logic [CNT_W-1:0]     r_pkt_cnt;
  logic                 r_sof;
  logic                 r_done;
  logic                 r_timed_out;
  logic                 r_cfg_err;

  logic                 w_hs;
  logic                 w_armed;
  logic [NUM_PAT-1:0]   w_match;
  logic [NUM_PAT-1:0]   w_hit_nxt;

  assign w_hs    = s_axis_tvalid & s_axis_tready;
  assign w_armed = (r_state == ARMED);

  always_comb begin
    w_match = '0;
    for (int i = 0; i < NUM_PAT; i++) begin
      w_match[i] = r_en_q[i] &&
        (((s_axis_tdata ^ r_pat[i]) & r_mask[i]) == '0);
    end
    w_hit_nxt = r_hit | (w_match & {NUM_PAT{w_hs & r_sof}});
  end

  // Slot RAM has no reset; writes are blocked while a window is open.
  always_ff @(posedge clk) begin
    if (cfg_we && !w_armed) begin
      for (int i = 0; i < NUM_PAT; i++) begin
        if (cfg_idx == IDX_W'(i)) begin
          r_pat[i]  <= cfg_pattern;
          r_mask[i] <= cfg_mask;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_en_q      <= '0;
      r_hit       <= '0;
      r_timer     <= '0;
      r_pkt_cnt   <= '0;
      r_sof       <= 1'b1;
      r_done      <= 1'b0;
      r_timed_out <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_cfg_err <= cfg_we && w_armed;
      if (w_hs) r_sof <= s_axis_tlast;
      if (arm) begin
        r_state     <= ARMED;
        r_en_q      <= cfg_en;
        r_timer     <= timeout_cycles;
        r_hit       <= '0;
        r_pkt_cnt   <= '0;
        r_done      <= 1'b0;
        r_timed_out <= 1'b0;
      end else if (w_armed) begin
        r_hit <= w_hit_nxt;
        if (w_hs && s_axis_tlast && (r_pkt_cnt != '1))
          r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
        // Completion takes priority over an expiring timer.
        if ((w_hit_nxt & r_en_q) == r_en_q) begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end else if (r_timer == '0) begin
          r_state     <= TMO;
          r_timed_out <= 1'b1;
        end else begin
          r_timer <= r_timer - TIMER_W'(1);
        end
      end
    end
  end

  assign busy      = w_armed;
  assign done      = r_done;
  assign timed_out = r_timed_out;
  assign hit       = r_hit;
  assign pkt_cnt   = r_pkt_cnt;
  assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_axis_pattern_checker.sv
// Scoreboard bench for axis_pattern_checker: directed stimulus pushes
// expected status, a negedge monitor pops and compares.
module tb_axis_pattern_checker;

  localparam int DW = 512;

  logic          clk;
  logic          rst;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;
  logic          cfg_we;
  logic [1:0]    cfg_idx;
  logic [DW-1:0] cfg_pattern;
  logic [DW-1:0] cfg_mask;
  logic [3:0]    cfg_en;
  logic          arm;
  logic [15:0]   tmo;

  logic          busy, done, timed_out, cfg_err;
  logic [3:0]    hit;
  logic [15:0]   pkt_cnt;
  logic          busy2, done2, to2, cerr2;
  logic [3:0]    hit2;
  logic [1:0]    cnt2;

  axis_pattern_checker #(.DATA_W(DW), .NUM_PAT(4), .TIMER_W(16),
                         .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready), .s_axis_tlast(tlast),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
    .cfg_en(cfg_en), .arm(arm), .timeout_cycles(tmo),
    .busy(busy), .done(done), .timed_out(timed_out),
    .hit(hit), .pkt_cnt(pkt_cnt), .cfg_err(cfg_err)
  );

  axis_pattern_checker #(.DATA_W(DW), .NUM_PAT(4), .TIMER_W(16),
                         .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready), .s_axis_tlast(tlast),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
    .cfg_en(cfg_en), .arm(arm), .timeout_cycles(tmo),
    .busy(busy2), .done(done2), .timed_out(to2),
    .hit(hit2), .pkt_cnt(cnt2), .cfg_err(cerr2)
  );

  typedef struct {
    string       nm;
    logic [3:0]  hit;
    logic        done;
    logic        to;
    logic        busy;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
    logic        cerr;
  } exp_t;

  exp_t sbq[$];
  logic smp;
  int   total;
  int   bad;

  logic [DW-1:0] p1, p2, p2x, p3, px, ones, m2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare one expected record per sample strobe.
  always @(negedge clk) begin
    if (smp) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_empty: no expected record");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (hit !== e.hit || done !== e.done || timed_out !== e.to ||
            busy !== e.busy || pkt_cnt !== e.cnt || cnt2 !== e.cnt2 ||
            cfg_err !== e.cerr) begin
          bad++;
          $display("FAIL %s: got hit=%b done=%b to=%b busy=%b cnt=%0d cnt2=%0d cerr=%b want hit=%b done=%b to=%b busy=%b cnt=%0d cnt2=%0d cerr=%b",
                   e.nm, hit, done, timed_out, busy, pkt_cnt, cnt2, cfg_err,
                   e.hit, e.done, e.to, e.busy, e.cnt, e.cnt2, e.cerr);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [3:0] h, logic d, logic t,
                     logic b, logic [15:0] c, logic e);
    exp_t x;
    x.nm   = nm;
    x.hit  = h;
    x.done = d;
    x.to   = t;
    x.busy = b;
    x.cnt  = c;
    x.cnt2 = (c > 16'd3) ? 2'd3 : c[1:0];
    x.cerr = e;
    sbq.push_back(x);
    smp = 1'b1;
    @(negedge clk);
    #1;
    smp = 1'b0;
  endtask

  task automatic chk_int(string nm, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  task automatic cfg_write(logic [1:0] idx, logic [DW-1:0] p,
                           logic [DW-1:0] m);
    cfg_we = 1'b1;
    cfg_idx = idx;
    cfg_pattern = p;
    cfg_mask = m;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic do_arm(logic [3:0] en, logic [15:0] t);
    arm = 1'b1;
    cfg_en = en;
    tmo = t;
    step();
    arm = 1'b0;
  endtask

  task automatic beat(logic [DW-1:0] d, logic l, logic r);
    tdata = d;
    tvalid = 1'b1;
    tready = r;
    tlast = l;
    step();
    tvalid = 1'b0;
    tready = 1'b0;
    tlast = 1'b0;
  endtask

  initial begin
    int n;
    total = 0;
    bad = 0;
    smp = 1'b0;
    rst = 1'b1;
    tdata = '0;
    tvalid = 1'b0;
    tready = 1'b0;
    tlast = 1'b0;
    cfg_we = 1'b0;
    cfg_idx = '0;
    cfg_pattern = '0;
    cfg_mask = '0;
    cfg_en = '0;
    arm = 1'b0;
    tmo = '0;
    p1 = {16{32'hA5A5_0001}};
    p2 = {16{32'h1234_5678}};
    p3 = {16{32'h0F0F_3333}};
    px = {16{32'hDEAD_BEEF}};
    ones = '1;
    m2 = '1;
    m2[383:352] = 32'h0;
    p2x = p2;
    p2x[383:352] = 32'h0000_0005;

    step();
    step();
    rst = 1'b0;
    step();
    chk("reset", 4'b0000, 0, 0, 0, 16'd0, 0);

    cfg_write(2'd0, p1, ones);
    cfg_write(2'd1, p2, m2);
    cfg_write(2'd2, p3, ones);
    cfg_write(2'd3, p3, ones);

    do_arm(4'b0001, 16'd1000);
    chk("t1_armed", 4'b0000, 0, 0, 1, 16'd0, 0);
    beat(p1, 1'b1, 1'b1);
    chk("t1_done", 4'b0001, 1, 0, 0, 16'd1, 0);

    do_arm(4'b0011, 16'd1000);
    beat(p2x, 1'b1, 1'b1);
    chk("t2_hit1", 4'b0010, 0, 0, 1, 16'd1, 0);
    beat(p1, 1'b1, 1'b1);
    chk("t2_done", 4'b0011, 1, 0, 0, 16'd2, 0);

    do_arm(4'b0001, 16'd1000);
    beat(px, 1'b0, 1'b1);
    beat(p1, 1'b0, 1'b0);
    beat(p1, 1'b0, 1'b1);
    beat(p1, 1'b1, 1'b1);
    chk("t3_midpkt", 4'b0000, 0, 0, 1, 16'd1, 0);
    beat(p1, 1'b1, 1'b1);
    chk("t3_done", 4'b0001, 1, 0, 0, 16'd2, 0);

    do_arm(4'b0001, 16'd20);
    n = 0;
    while (busy && n < 100) begin
      n++;
      step();
    end
    chk_int("t4_busy_cycles", n, 21);
    chk("t4_timeout", 4'b0000, 0, 1, 0, 16'd0, 0);
    beat(p1, 1'b1, 1'b1);
    chk("t4_frozen", 4'b0000, 0, 1, 0, 16'd0, 0);

    do_arm(4'b0001, 16'd3);
    step();
    step();
    step();
    beat(p1, 1'b1, 1'b1);
    chk("t5_tie_done", 4'b0001, 1, 0, 0, 16'd1, 0);

    do_arm(4'b0001, 16'd1000);
    cfg_write(2'd0, p3, ones);
    chk("t5_cfg_err", 4'b0000, 0, 0, 1, 16'd0, 1);
    step();
    chk("t5_cfg_err_end", 4'b0000, 0, 0, 1, 16'd0, 0);
    beat(p1, 1'b1, 1'b1);
    chk("t5_slot_kept", 4'b0001, 1, 0, 0, 16'd1, 0);

    do_arm(4'b0000, 16'd1000);
    chk("t6_en0_armed", 4'b0000, 0, 0, 1, 16'd0, 0);
    step();
    chk("t6_en0_done", 4'b0000, 1, 0, 0, 16'd0, 0);

    do_arm(4'b0001, 16'd0);
    chk("t6_tmo0_armed", 4'b0000, 0, 0, 1, 16'd0, 0);
    step();
    chk("t6_tmo0_to", 4'b0000, 0, 1, 0, 16'd0, 0);

    do_arm(4'b0001, 16'd1000);
    for (int i = 0; i < 5; i++) beat(px, 1'b1, 1'b1);
    chk("t6_cnt_sat", 4'b0000, 0, 0, 1, 16'd5, 0);

    do_arm(4'b0011, 16'd1000);
    beat(p2x, 1'b1, 1'b1);
    chk("t6_pre_rst", 4'b0010, 0, 0, 1, 16'd1, 0);
    rst = 1'b1;
    step();
    chk("t6_rst", 4'b0000, 0, 0, 0, 16'd0, 0);
    rst = 1'b0;
    step();
    chk("t6_post_rst", 4'b0000, 0, 0, 0, 16'd0, 0);

    step();
    chk_int("scoreboard_left", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
